// File: rtl/io_channel_bank_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_pkg : shared types and constants for io_channel_bank.        Rev 1.0
// ----------------------------------------------------------------------------
package io_pkg;

   typedef logic [14:0] io_word_t;

   localparam logic [2:0] CH_TX     = 3'd4;
   localparam logic [2:0] CH_RX     = 3'd5;
   localparam logic [2:0] CH_STATUS = 3'd6;
   localparam logic [2:0] CH_DISC   = 3'd7;

   localparam int ST_CNT_LSB = 0;
   localparam int ST_CNT_MSB = 3;
   localparam int ST_EMPTY   = 4;
   localparam int ST_FULL    = 5;
   localparam int ST_RX_FULL = 6;
   localparam int ST_OVF     = 7;

   function automatic io_word_t pack_status(input logic ovf, input logic rx_full,
                                            input logic full, input logic empty,
                                            input logic [3:0] cnt);
      io_word_t s;
      s = '0;
      s[ST_OVF]                = ovf;
      s[ST_RX_FULL]            = rx_full;
      s[ST_FULL]               = full;
      s[ST_EMPTY]              = empty;
      s[ST_CNT_MSB:ST_CNT_LSB] = cnt;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/io_channel_bank_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_channel_bank_if : core bus plus TX/RX device handshakes.     Rev 1.0
// ----------------------------------------------------------------------------
interface io_channel_bank_if;
   import io_pkg::*;

   logic [2:0] IO_read_sel;
   logic       IO_read_en;
   logic [2:0] IO_write_sel;
   io_word_t   IO_write_data;
   logic       IO_write_en;
   io_word_t   IO_read_data;
   io_word_t   out_data;
   logic       out_valid;
   logic       out_ready;
   io_word_t   in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (
      output IO_read_sel, IO_read_en, IO_write_sel, IO_write_data, IO_write_en,
      output out_ready, in_data, in_valid,
      input  IO_read_data, out_data, out_valid, in_ready
   );

   modport slave (
      input  IO_read_sel, IO_read_en, IO_write_sel, IO_write_data, IO_write_en,
      input  out_ready, in_data, in_valid,
      output IO_read_data, out_data, out_valid, in_ready
   );

endinterface
`default_nettype wire

// File: rtl/io_channel_bank_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_fifo : TX FIFO, power-of-2 DEPTH, head zeroed while empty.   Rev 1.0
// ----------------------------------------------------------------------------
module io_fifo
   import io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  io_word_t                     push_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output io_word_t                     head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

   io_word_t        r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_do_push;
   logic            w_do_pop;

   assign full      = (r_count == c_FULL);
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign head      = empty ? '0 : r_mem[r_rd_ptr];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_do_push = push && (!full || pop);
   assign w_do_pop  = pop && !empty;

   always_ff @(posedge clock) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/io_channel_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_channel_bank : 8-channel I/O bank (latches, TX FIFO, RX, STATUS, DISC).
// Define IO_DISCRETE_SYNC_EN for a 2-flop discrete synchronizer.   Rev 1.0
// ----------------------------------------------------------------------------
module io_channel_bank
   import io_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  io_word_t          discrete_in,
   io_channel_bank_if.slave  bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   io_word_t        r_lat [4];
   io_word_t        r_rx_data;
   logic            r_rx_full;
   logic            r_ovf;
   io_word_t        r_disc;

   logic            w_wr_latch;
   logic            w_push;
   logic            w_pop;
   logic            w_push_drop;
   logic            w_ovf_clr;
   logic            w_rx_clr;
   logic            w_capture;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   logic [CW-1:0]   w_count;
   logic [CW+3:0]   w_cnt_ext;
   logic [3:0]      w_cnt_field;
   io_word_t        w_head;
   io_word_t        w_status;
   io_word_t        w_read_data;

   assign w_wr_latch  = bus.IO_write_en && !bus.IO_write_sel[2];
   assign w_push      = bus.IO_write_en && (bus.IO_write_sel == CH_TX);
   assign w_pop       = bus.out_ready && !w_fifo_empty;
   assign w_push_drop = w_push && w_fifo_full && !w_pop;
   assign w_ovf_clr   = bus.IO_write_en && (bus.IO_write_sel == CH_STATUS) && bus.IO_write_data[0];
   assign w_rx_clr    = bus.IO_read_en && (bus.IO_read_sel == CH_RX);
   assign w_capture   = bus.in_valid && !r_rx_full;

   assign bus.out_data  = w_head;
   assign bus.out_valid = !w_fifo_empty;
   assign bus.in_ready  = !r_rx_full;

   io_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (bus.IO_write_data),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty),
      .count     (w_count),
      .head      (w_head)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            r_lat[i] <= '0;
         end
      end else if (w_wr_latch) begin
         r_lat[bus.IO_write_sel[1:0]] <= bus.IO_write_data;
      end
   end

   // Overflow set beats a same-cycle software clear; RX clear beats capture.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ovf     <= 1'b0;
         r_rx_full <= 1'b0;
         r_rx_data <= '0;
      end else begin
         if (w_push_drop) begin
            r_ovf <= 1'b1;
         end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
         end
         if (w_rx_clr) begin
            r_rx_full <= 1'b0;
         end else if (w_capture) begin
            r_rx_full <= 1'b1;
            r_rx_data <= bus.in_data;
         end
      end
   end

`ifdef IO_DISCRETE_SYNC_EN
   io_word_t r_disc_meta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_disc_meta <= '0;
         r_disc      <= '0;
      end else begin
         r_disc_meta <= discrete_in;
         r_disc      <= r_disc_meta;
      end
   end
`else
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_disc <= '0;
      end else begin
         r_disc <= discrete_in;
      end
   end
`endif

   // Count field saturates at 15 for deeper FIFOs.
   assign w_cnt_ext   = {4'b0000, w_count};
   assign w_cnt_field = (|w_cnt_ext[CW+3:4]) ? 4'hF : w_cnt_ext[3:0];
   assign w_status    = pack_status(r_ovf, r_rx_full, w_fifo_full, w_fifo_empty, w_cnt_field);

   always_comb begin
      w_read_data = '0;
      case (bus.IO_read_sel)
         3'd0, 3'd1, 3'd2, 3'd3: w_read_data = r_lat[bus.IO_read_sel[1:0]];
         CH_TX:                  w_read_data = '0;
         CH_RX:                  w_read_data = r_rx_full ? r_rx_data : '0;
         CH_STATUS:              w_read_data = w_status;
         CH_DISC:                w_read_data = r_disc;
         default:                w_read_data = '0;
      endcase
   end

   assign bus.IO_read_data = w_read_data;

endmodule
`default_nettype wire

// File: tb/tb_io_channel_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_io_channel_bank : directed self-checking bench for io_channel_bank.
// ----------------------------------------------------------------------------
module tb_io_channel_bank;
   import io_pkg::*;

   logic     clock = 1'b0;
   logic     reset = 1'b1;
   io_word_t discrete_in = '0;
   int       n_tests = 0;
   int       n_fail  = 0;

   io_channel_bank_if bus();

   io_channel_bank #(
      .FIFO_DEPTH  (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .discrete_in (discrete_in),
      .bus         (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] sel, input logic [14:0] exp);
      bus.IO_read_sel = sel;
      #1;
      chk(tag, bus.IO_read_data, exp);
   endtask

   initial begin
      bus.IO_read_sel   = 3'd0;
      bus.IO_read_en    = 1'b0;
      bus.IO_write_sel  = 3'd0;
      bus.IO_write_data = '0;
      bus.IO_write_en   = 1'b0;
      bus.out_ready     = 1'b0;
      bus.in_data       = '0;
      bus.in_valid      = 1'b0;

      // reset state
      #2;
      chk("rst_out_valid", 15'(bus.out_valid), 15'd0);
      chk("rst_in_ready",  15'(bus.in_ready),  15'd1);
      chk("rst_out_data",  bus.out_data,       15'd0);
      for (int s = 0; s < 6; s++) begin
         rd_chk($sformatf("rst_rd%0d", s), 3'(s), 15'd0);
      end
      rd_chk("rst_status", CH_STATUS, 15'h0010);
      rd_chk("rst_disc",   CH_DISC,   15'd0);
      tick();
      tick();
      reset = 1'b0;

      // output latches, no write-to-read bypass
      bus.IO_write_sel  = 3'd2;
      bus.IO_write_data = 15'o12345;
      bus.IO_write_en   = 1'b1;
      rd_chk("ch2_same_cycle", 3'd2, 15'd0);
      tick();
      bus.IO_write_en = 1'b0;
      rd_chk("ch2_readback", 3'd2, 15'o12345);
      bus.IO_write_sel  = 3'd3;
      bus.IO_write_data = 15'h7FFF;
      bus.IO_write_en   = 1'b1;
      tick();
      bus.IO_write_en = 1'b0;
      rd_chk("ch3_readback", 3'd3, 15'h7FFF);
      rd_chk("ch0_untouched", 3'd0, 15'd0);
      rd_chk("ch2_kept", 3'd2, 15'o12345);

      // writes to read-only channels are ignored
      bus.IO_write_sel  = CH_DISC;
      bus.IO_write_data = 15'h1234;
      bus.IO_write_en   = 1'b1;
      tick();
      bus.IO_write_sel = CH_RX;
      tick();
      bus.IO_write_en = 1'b0;
      rd_chk("ch7_wr_ignored", CH_DISC, 15'd0);
      rd_chk("ch5_wr_ignored", CH_RX,   15'd0);
      chk("ch5_wr_in_ready", 15'(bus.in_ready), 15'd1);

      // fill past full with the consumer stalled
      bus.IO_write_sel = CH_TX;
      bus.IO_write_en  = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         bus.IO_write_data = 15'(i);
         tick();
      end
      bus.IO_write_en = 1'b0;
      rd_chk("st_full_ovf", CH_STATUS, 15'h00A4);
      rd_chk("ch4_reads_0", CH_TX, 15'd0);
      chk("tx_valid_full", 15'(bus.out_valid), 15'd1);
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("drain_a%0d", i), bus.out_data, 15'(i));
         tick();
      end
      chk("drain_a_valid0", 15'(bus.out_valid), 15'd0);
      chk("drain_a_data0",  bus.out_data,       15'd0);
      bus.out_ready = 1'b0;
      rd_chk("st_empty_ovf", CH_STATUS, 15'h0090);
      bus.IO_write_sel  = CH_STATUS;
      bus.IO_write_data = 15'd1;
      bus.IO_write_en   = 1'b1;
      tick();
      bus.IO_write_en = 1'b0;
      rd_chk("st_ovf_cleared", CH_STATUS, 15'h0010);

      // push and pop together on a full FIFO
      bus.IO_write_sel = CH_TX;
      bus.IO_write_en  = 1'b1;
      for (int i = 10; i <= 13; i++) begin
         bus.IO_write_data = 15'(i);
         tick();
      end
      bus.IO_write_en = 1'b0;
      rd_chk("st_full_again", CH_STATUS, 15'h0024);
      bus.out_ready     = 1'b1;
      bus.IO_write_data = 15'd7;
      bus.IO_write_en   = 1'b1;
      tick();
      bus.IO_write_en = 1'b0;
      bus.out_ready   = 1'b0;
      rd_chk("st_push_pop_full", CH_STATUS, 15'h0024);
      bus.out_ready = 1'b1;
      chk("drain_b0", bus.out_data, 15'd11);
      tick();
      chk("drain_b1", bus.out_data, 15'd12);
      tick();
      chk("drain_b2", bus.out_data, 15'd13);
      tick();
      chk("drain_b3", bus.out_data, 15'd7);
      tick();
      chk("drain_b_valid0", 15'(bus.out_valid), 15'd0);
      bus.out_ready = 1'b0;

      // RX holding register
      chk("rx_ready_idle", 15'(bus.in_ready), 15'd1);
      bus.in_data  = 15'o777;
      bus.in_valid = 1'b1;
      tick();
      bus.in_data = 15'h0123;
      chk("rx_ready_held", 15'(bus.in_ready), 15'd0);
      rd_chk("rx_data", CH_RX, 15'o777);
      tick();
      bus.in_valid = 1'b0;
      rd_chk("rx_no_overwrite", CH_RX, 15'o777);
      rd_chk("st_rx_full", CH_STATUS, 15'h0050);
      bus.IO_read_en = 1'b1;
      tick();
      bus.IO_read_en = 1'b0;
      rd_chk("rx_strobe_other_ch", CH_RX, 15'o777);
      bus.IO_read_en = 1'b1;
      tick();
      bus.IO_read_en = 1'b0;
      chk("rx_ready_after_rd", 15'(bus.in_ready), 15'd1);
      rd_chk("rx_cleared", CH_RX, 15'd0);

      // discrete input latency
      discrete_in = 15'h2AAA;
      rd_chk("disc_t0", CH_DISC, 15'd0);
      tick();
`ifdef IO_DISCRETE_SYNC_EN
      rd_chk("disc_t1", CH_DISC, 15'd0);
`else
      rd_chk("disc_t1", CH_DISC, 15'h2AAA);
`endif
      tick();
      rd_chk("disc_t2", CH_DISC, 15'h2AAA);

      // reset mid-transfer
      bus.IO_write_sel  = CH_TX;
      bus.IO_write_en   = 1'b1;
      bus.IO_write_data = 15'd21;
      bus.in_data       = 15'o55;
      bus.in_valid      = 1'b1;
      tick();
      bus.in_valid      = 1'b0;
      bus.IO_write_data = 15'd22;
      tick();
      bus.IO_write_data = 15'd23;
      tick();
      bus.IO_write_en = 1'b0;
      rd_chk("st_before_rst", CH_STATUS, 15'h0043);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", 15'(bus.out_valid), 15'd0);
      chk("arst_in_ready",  15'(bus.in_ready),  15'd1);
      chk("arst_out_data",  bus.out_data,       15'd0);
      rd_chk("arst_status", CH_STATUS, 15'h0010);
      rd_chk("arst_rx",     CH_RX,     15'd0);
      rd_chk("arst_ch2",    3'd2,      15'd0);
      rd_chk("arst_disc",   CH_DISC,   15'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_valid", 15'(bus.out_valid), 15'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/io_channel_bank.md
IO_CHANNEL_BANK -- requirements
Module: io_channel_bank

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: output FIFO depth; SHALL be a power of 2, minimum 2.
REQ-002 Port clock, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1: reset is asynchronous and active-high.
REQ-004 Ports driven by the core: IO_read_sel (input, 3, read channel select), IO_read_en (input, 1, read strobe), IO_write_sel (input, 3, write channel select), IO_write_data (input, 15, write data) and IO_write_en (input, 1, write strobe).
REQ-005 Port IO_read_data, output, 15: read data for IO_read_sel; it SHALL be combinational from registered state only.
REQ-006 Output-device ports: out_data (output, 15), out_valid (output, 1) and out_ready (input, 1) form a valid/ready handshake.
REQ-007 Input-device ports: in_data (input, 15), in_valid (input, 1) and in_ready (output, 1) form a valid/ready handshake.
REQ-008 Port discrete_in, input, 15: asynchronous discrete inputs.

Function
REQ-009 Channels 0-3 SHALL be 15-bit output latches.
- A write loads the latch.
- A read returns the latched value.
REQ-010 Channel 4 (TX) SHALL behave as follows.
- A write pushes IO_write_data into the FIFO.
- A write when the FIFO is full is dropped and sets sticky ovf.
- A read returns 0.
REQ-011 The FIFO head SHALL drive out_data, and out_valid SHALL equal not-empty; the head pops when out_valid and out_ready are both 1.
REQ-012 A push and a pop in the same cycle SHALL both take effect.
- Count stays unchanged.
- When full, a push with a simultaneous pop is accepted and ovf is not set.
REQ-013 Channel 5 (RX) SHALL use a one-entry holding register rx_data with flag rx_full.
- in_ready = ~rx_full.
- in_valid with in_ready captures in_data and sets rx_full on the next edge.
REQ-014 A channel 5 read SHALL return rx_data, or 0 when rx_full=0; IO_read_en on channel 5 clears rx_full at the next edge.
REQ-015 If a capture and a clear occur in the same cycle, the clear SHALL win; a capture in that cycle is impossible because in_ready=0.
REQ-016 Channel 6 (STATUS) SHALL read back {7'b0, ovf, rx_full, fifo_full, fifo_empty, count[3:0]}; count saturates the field at 15.
- A write with bit 0 = 1 clears ovf.
- If a clear and an overflow occur in the same cycle, ovf ends up set.
REQ-017 Channel 7 (DISCRETE) SHALL be read-only and return the synchronized discrete_in.
REQ-018 Writes to channels 5 and 7, and read strobes to channels other than 5, SHALL have no effect.
REQ-019 A write takes effect at the next edge; a read in that same cycle of the same channel SHALL return the old value (no bypass).
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.

Reset
REQ-021 On reset assertion the following SHALL clear asynchronously to zero:
- channel latches 0-3, FIFO pointers and count, rx_data, rx_full, ovf, synchronizer flops.
- The resulting outputs are out_valid=0, in_ready=1, out_data=0 and IO_read_data=0 for every select.
REQ-022 Reset mid-transfer SHALL discard all FIFO contents and any held RX word; no handshake completes during the reset cycle.

Configuration
REQ-023 With IO_DISCRETE_SYNC_EN defined, discrete_in SHALL pass through a 2-flop synchronizer, giving 2-cycle latency to channel 7.
REQ-024 Without IO_DISCRETE_SYNC_EN, channel 7 SHALL read a single register of discrete_in, giving 1-cycle latency.

Structure
REQ-025 Shared package io_pkg SHALL hold:
- the channel-number localparams CH_TX=4, CH_RX=5, CH_STATUS=6 and CH_DISC=7;
- the STATUS bit-position constants;
- a typedef for the 15-bit word.
REQ-026 Sub-module io_fifo (parameter DEPTH) SHALL implement the TX FIFO with push, pop, full, empty, count and head ports; all other logic stays in io_channel_bank.

Verification
REQ-027 Write ch2=15'o12345, then read ch2 -> 15'o12345; a same-cycle read of ch2 returns the prior value 0.
REQ-028 With out_ready=0, write ch4 five times (1..5) -> STATUS = count 4, full=1, ovf=1.
- Raise out_ready -> out_data 1,2,3,4 on consecutive cycles, then out_valid=0.
REQ-029 Full FIFO, out_ready=1 plus a ch4 write of 7 in the same cycle -> count stays 4, ovf=0, and 7 emerges last.
REQ-030 in_valid=1 with in_data=15'o777 -> in_ready=0 next cycle and a ch5 read returns 15'o777.
- Read with IO_read_en -> in_ready=1 next cycle and a ch5 read returns 0.
REQ-031 Toggle discrete_in to 15'h2AAA -> channel 7 shows it after 2 cycles with the macro defined, 1 cycle without.
REQ-032 Assert reset with the FIFO holding 3 words and rx_full=1 -> out_valid=0, in_ready=1, STATUS=15'h0010 (count 0, empty=1) immediately, without waiting for a clock edge.
